// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BHT of 2-bit saturating counters plus BTB targets.
// Trained from EX resolutions; raises flush/redirect on mispredict and keeps branch statistics.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic               valid_r  [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];
  logic [31:0]        br_cnt_r;
  logic [31:0]        mis_cnt_r;

  logic [IDX_W-1:0]   if_idx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic               if_hit_s;
  logic [IDX_W-1:0]   ex_idx_s;
  logic [TAG_W-1:0]   ex_tag_s;
  logic               ex_hit_s;
  logic               mispredict_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      return 2'b11;
    end else begin
      return c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      return 2'b00;
    end else begin
      return c - 2'b01;
    end
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Fetch-side lookup: reads pre-update table contents, no bypass from EX.
  always_comb begin
    if_idx_s   = if_pc[IDX_W+1:2];
    if_tag_s   = if_pc[31:IDX_W+2];
    if_hit_s   = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    pred_taken = if_hit_s && ctr_r[if_idx_s][1];
    if (pred_taken) begin
      pred_target = target_r[if_idx_s];
    end else begin
      pred_target = if_pc + 32'd4;
    end
  end

  // EX-side resolution: mispredict detection and the corrected next PC.
  always_comb begin
    ex_idx_s     = ex_pc[IDX_W+1:2];
    ex_tag_s     = ex_pc[31:IDX_W+2];
    ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    mispredict_s = ex_is_branch &&
                   ((ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_pred_target != ex_target)));
    // Gated by rst_n so a flush cannot escape while the pipeline is held in reset.
    flush = mispredict_s && rst_n;
    if (ex_taken) begin
      redirect_pc = ex_target;
    end else begin
      redirect_pc = ex_pc + 32'd4;
    end
  end

  // Table training from resolved branches; a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (ex_is_branch) begin
      if (ex_hit_s) begin
        if (ex_taken) begin
          ctr_r[ex_idx_s]    <= ctr_inc(ctr_r[ex_idx_s]);
          target_r[ex_idx_s] <= ex_target;
        end else begin
          ctr_r[ex_idx_s]    <= ctr_dec(ctr_r[ex_idx_s]);
        end
      end else if (ex_taken) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= ex_target;
        ctr_r[ex_idx_s]    <= 2'b10;
      end else begin
        valid_r[ex_idx_s]  <= valid_r[ex_idx_s];
      end
    end else begin
      valid_r[ex_idx_s] <= valid_r[ex_idx_s];
    end
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r  <= 32'd0;
      mis_cnt_r <= 32'd0;
    end else begin
      if (ex_is_branch) begin
        br_cnt_r <= sat_inc32(br_cnt_r);
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      if (mispredict_s) begin
        mis_cnt_r <= sat_inc32(mis_cnt_r);
      end else begin
        mis_cnt_r <= mis_cnt_r;
      end
    end
  end

  assign br_cnt  = br_cnt_r;
  assign mis_cnt = mis_cnt_r;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage dynamic branch predictor: a direct-mapped table of 2-bit saturating counters plus target entries (BHT+BTB).
- Predicts direction and target for the PC being fetched.
- Trained by branch outcomes resolved in EX, where the resolved taken bit comes from the branch decision logic.
- Detects mispredictions and drives the pipeline flush/redirect, and keeps branch/mispredict statistics counters.

Parameters:
- ENTRIES, 16, table depth; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width, derived (not overridden).
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  32  predicted next PC for if_pc.
- ex_is_branch  in  1  valid conditional branch resolving in EX. Must be 0 for bubbles and flushed slots.
- ex_pc  in  32  PC of the resolving branch.
- ex_taken  in  1  resolved direction (branch_taken).
- ex_target  in  32  resolved taken target.
- ex_pred_taken  in  1  prediction carried with the branch through IF/ID and ID/EX.
- ex_pred_target  in  32  predicted target carried with the branch.
- flush  out  1  misprediction: flush IF/ID and ID/EX.
- redirect_pc  out  32  correct next PC when flush=1.
- br_cnt  out  32  count of resolved branches.
- mis_cnt  out  32  count of mispredictions.

Behaviour:
- Entry state: valid(1), tag(32-IDX_W-2), target(32), ctr(2).
- Reset (async, rst_n=0):
  - Every entry: valid=0, ctr=2'b01.
  - br_cnt=0, mis_cnt=0.
  - flush forced to 0 while rst_n=0.
  - Reset may assert mid-operation; no partial update may survive it.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
  - Output of an empty table after reset: pred_taken=0, pred_target=if_pc+4.
- Misprediction (combinational, same cycle as EX):
  - mispredict = ex_is_branch && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)).
  - flush = mispredict.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4. It is driven for every resolution; it is meaningful only while flush=1.
- Update (rising edge, when ex_is_branch=1; index and tag taken from ex_pc):
  - Hit, taken: ctr saturating +1 (max 11), target <= ex_target.
  - Hit, not taken: ctr saturating -1 (min 00), target unchanged.
  - Miss, taken: allocate or replace. valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no write.
- Statistics:
  - br_cnt += 1 when ex_is_branch=1.
  - mis_cnt += 1 when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF.
- Simultaneous lookup and update at the same index: lookup returns the pre-update contents (no bypass). The new state is visible the next cycle.
- No stall input: the caller deasserts ex_is_branch during stalls so that one branch updates exactly once.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; br_cnt=mis_cnt=0.
- ex_is_branch=1, ex_pc=0x100, ex_taken=1, ex_target=0x080, ex_pred_taken=0 -> same cycle flush=1, redirect_pc=0x080. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x080; br_cnt=1, mis_cnt=1.
- Training from ctr=10 on pc 0x100:
  - Taken with ex_pred_taken=1 and matching target -> ctr=11, flush=0.
  - Then not-taken -> flush=1, redirect_pc=0x104, ctr=10, still predicts taken.
  - Second not-taken -> ctr=01, pred_taken=0; mis_cnt +2 in total.
- Aliasing (ENTRIES=16): branch at 0x140 (index 0, different tag) resolved taken to 0x200 -> replaces entry 0. Afterwards if_pc=0x100 -> pred_taken=0; if_pc=0x140 -> pred_target=0x200. A not-taken miss at 0x180 -> no table change and flush=0.
- Same cycle: if_pc=0x100 while updating index 0 -> lookup shows old entry; next cycle shows new entry.
- Assert rst_n=0 asynchronously mid-cycle while flush=1 -> flush drops immediately, counters read 0, all lookups miss after release.
